command_queue: RTL and testbench

- Elastic command buffer between the I2C slave and the TPU.
- Captures 48-bit commands delivered as single-cycle `execute` pulses, holds them in a circular FIFO, and replays them to the TPU one at a time, honouring the TPU `busy` handshake.
- Lets the I2C host burst commands while the TPU runs long video-memory operations.
- Back-pressures the I2C slave only when the FIFO is full.

---
 rtl/command_queue.sv | 155 +++++++++++++++
 tb/tb_command_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/command_queue.sv
// Elastic command FIFO between the I2C slave and the TPU.
// Buffers execute-strobed commands and replays them one at a time under the TPU busy handshake.
module command_queue #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned WIDTH        = 48,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_button,
  input  logic                  in_execute,
  input  logic [WIDTH-1:0]      in_command,
  output logic                  in_busy,
  output logic                  out_execute,
  output logic [WIDTH-1:0]      out_command,
  input  logic                  out_busy,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W   = DEPTH_LOG2;
  localparam int unsigned LVL_W   = DEPTH_LOG2 + 1;
  localparam int unsigned GUARD_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [1:0]         state;
  logic [1:0]         state_d;
  logic [GUARD_W-1:0] guard_cnt;
  logic [GUARD_W-1:0] guard_d;
  logic [LVL_W-1:0]   level_d;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               wr_drop;
  logic               pop;

  // Fullness is judged on the level at the start of the cycle, so a same-cycle pop never frees room.
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign wr_en   = in_execute & ~flush & ~full;
  assign wr_drop = in_execute & ~flush & full;

  // Dispatch FSM next-state logic.
  always_comb begin
    state_d = state;
    guard_d = guard_cnt;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !out_busy) begin
          pop     = 1'b1;
          guard_d = GUARD_W'(GUARD_CYCLES);
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        // out_busy is not trusted until the TPU has had time to raise it.
        if (guard_cnt <= GUARD_W'(1)) begin
          guard_d = '0;
          state_d = ST_WAIT;
        end else begin
          guard_d = guard_cnt - GUARD_W'(1);
        end
      end
      ST_WAIT: begin
        if (!out_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        guard_d = '0;
      end
    endcase
  end

  // Occupancy update; flush overrides everything.
  always_comb begin
    level_d = level;
    if (flush) begin
      level_d = '0;
    end else if (wr_en && !pop) begin
      level_d = level + LVL_W'(1);
    end else if (!wr_en && pop) begin
      level_d = level - LVL_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      state     <= ST_IDLE;
      guard_cnt <= '0;
    end else begin
      state     <= state_d;
      guard_cnt <= guard_d;
    end
  end

  // Pointers, level and status flags.
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      level   <= level_d;
      in_busy <= full;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (flush) begin
        rd_ptr   <= wr_ptr;
        overflow <= 1'b0;
      end else begin
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (wr_drop) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Dispatch outputs; out_command holds until the next pop.
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      out_execute <= 1'b0;
      out_command <= '0;
    end else begin
      out_execute <= pop;
      if (pop) begin
        out_command <= mem[rd_ptr];
      end
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_command;
    end
  end

endmodule

// File: tb/tb_command_queue.sv
// Directed bench for command_queue with a scoreboard of expected dispatches.
// A monitor pops the scoreboard on every out_execute and checks order and spacing.
module tb_command_queue;

  localparam int unsigned DEPTH_LOG2   = 4;
  localparam int unsigned WIDTH        = 48;
  localparam int unsigned GUARD_CYCLES = 2;

  logic              clk;
  logic              reset_button;
  logic              in_execute;
  logic [WIDTH-1:0]  in_command;
  logic              in_busy;
  logic              out_execute;
  logic [WIDTH-1:0]  out_command;
  logic              out_busy;
  logic              flush;
  logic [DEPTH_LOG2:0] level;
  logic              overflow;

  logic tpu_hold;
  logic tpu_busy;
  logic tpu_auto;

  int errors;
  int checks;
  int n_disp;
  int cyc;
  int last_cyc;
  bit have_last;
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] exp_c;

  assign out_busy = tpu_hold | tpu_busy;

  command_queue #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .WIDTH       (WIDTH),
    .GUARD_CYCLES(GUARD_CYCLES)
  ) dut (
    .clk         (clk),
    .reset_button(reset_button),
    .in_execute  (in_execute),
    .in_command  (in_command),
    .in_busy     (in_busy),
    .out_execute (out_execute),
    .out_command (out_command),
    .out_busy    (out_busy),
    .flush       (flush),
    .level       (level),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one write strobe; accepted commands go onto the scoreboard.
  task automatic wr(input logic [WIDTH-1:0] c, input bit accepted);
    if (accepted) sb.push_back(c);
    in_execute = 1'b1;
    in_command = c;
    @(negedge clk);
    in_execute = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(sb.size()), 0);
    repeat (8) @(negedge clk);
  endtask

  // TPU model: busy for three cycles after each dispatch it sees.
  initial begin
    tpu_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tpu_auto && out_execute && reset_button) begin
        tpu_busy = 1'b1;
        repeat (3) @(negedge clk);
        tpu_busy = 1'b0;
      end
    end
  end

  // Dispatch monitor.
  always @(negedge clk) begin
    cyc++;
    if (!reset_button) begin
      have_last = 1'b0;
    end else if (out_execute) begin
      n_disp++;
      chk("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_c = sb.pop_front();
        chk("dispatch_cmd", 64'(out_command), 64'(exp_c));
      end
      if (have_last) chk("dispatch_spacing", 64'((cyc - last_cyc) >= int'(GUARD_CYCLES + 2)), 1);
      have_last = 1'b1;
      last_cyc  = cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    errors = 0; checks = 0; n_disp = 0; cyc = 0; last_cyc = 0; have_last = 1'b0;
    reset_button = 1'b0; in_execute = 1'b0; in_command = '0; flush = 1'b0;
    tpu_hold = 1'b0; tpu_auto = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", 64'(level), 0);
    chk("rst_in_busy", 64'(in_busy), 0);
    chk("rst_out_execute", 64'(out_execute), 0);
    chk("rst_out_command", 64'(out_command), 0);
    chk("rst_overflow", 64'(overflow), 0);
    reset_button = 1'b1;
    @(negedge clk);

    // Single command latency.
    tpu_auto = 1'b1;
    wr(48'h0102_0304_0506, 1'b1);
    chk("t1_level_after_write", 64'(level), 1);
    chk("t1_no_exec_yet", 64'(out_execute), 0);
    @(negedge clk);
    chk("t1_exec", 64'(out_execute), 1);
    chk("t1_cmd", 64'(out_command), 48'h0102_0304_0506);
    chk("t1_level_after_pop", 64'(level), 0);
    @(negedge clk);
    chk("t1_exec_one_cycle", 64'(out_execute), 0);
    chk("t1_cmd_stable", 64'(out_command), 48'h0102_0304_0506);
    drain(50);

    // Ordering under TPU stall.
    tpu_hold = 1'b1;
    d0 = n_disp;
    for (int i = 1; i <= 5; i++) wr(48'(i), 1'b1);
    chk("t2_level5", 64'(level), 5);
    repeat (5) @(negedge clk);
    chk("t2_no_dispatch_while_busy", 64'(n_disp), 64'(d0));
    tpu_hold = 1'b0;
    drain(200);
    chk("t2_dispatch_count", 64'(n_disp), 64'(d0 + 5));

    // Full and overflow.
    tpu_hold = 1'b1;
    for (int i = 0; i < 16; i++) wr(48'h100 + 48'(i), 1'b1);
    chk("t3_level_full", 64'(level), 16);
    @(negedge clk);
    chk("t3_in_busy", 64'(in_busy), 1);
    chk("t3_no_overflow_yet", 64'(overflow), 0);
    wr(48'h111, 1'b0);
    chk("t3_level_stays", 64'(level), 16);
    chk("t3_overflow", 64'(overflow), 1);
    tpu_hold = 1'b0;
    drain(300);
    chk("t3_level_empty", 64'(level), 0);
    chk("t3_in_busy_clear", 64'(in_busy), 0);
    chk("t3_overflow_sticky", 64'(overflow), 1);

    // Wrap-around with interleaved dispatch.
    d0 = n_disp;
    for (int i = 0; i < 40; i++) begin
      wr(48'h2000 + 48'(i), 1'b1);
      chk("t4_level_bound", 64'(level <= 5), 1);
      repeat (4) @(negedge clk);
    end
    drain(200);
    chk("t4_dispatch_count", 64'(n_disp), 64'(d0 + 40));

    // Flush with in-flight command and simultaneous write.
    wr(48'hABCD_0000_0001, 1'b1);
    @(negedge clk);
    chk("t5_inflight_exec", 64'(out_execute), 1);
    tpu_hold = 1'b1;
    for (int i = 0; i < 6; i++) wr(48'h3000 + 48'(i), 1'b0);
    chk("t5_level6", 64'(level), 6);
    chk("t5_overflow_before", 64'(overflow), 1);
    flush = 1'b1; in_execute = 1'b1; in_command = 48'hDEAD;
    @(negedge clk);
    flush = 1'b0; in_execute = 1'b0;
    chk("t5_level_flushed", 64'(level), 0);
    chk("t5_overflow_cleared", 64'(overflow), 0);
    chk("t5_cmd_stable", 64'(out_command), 48'hABCD_0000_0001);
    @(negedge clk);
    chk("t5_in_busy", 64'(in_busy), 0);
    d0 = n_disp;
    tpu_hold = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_no_dispatch", 64'(n_disp), 64'(d0));
    chk("t5_cmd_still_stable", 64'(out_command), 48'hABCD_0000_0001);
    chk("t5_overflow_stays_clear", 64'(overflow), 0);

    // Asynchronous reset while in GUARD.
    wr(48'h5555_0000_0001, 1'b1);
    wr(48'h5555_0000_0002, 1'b1);
    chk("t6_exec_before_reset", 64'(out_execute), 1);
    chk("t6_level_before_reset", 64'(level), 1);
    #1 reset_button = 1'b0;
    #1;
    chk("t6_rst_out_execute", 64'(out_execute), 0);
    chk("t6_rst_level", 64'(level), 0);
    chk("t6_rst_in_busy", 64'(in_busy), 0);
    chk("t6_rst_out_command", 64'(out_command), 0);
    sb.delete();
    @(negedge clk);
    #1 reset_button = 1'b1;
    @(negedge clk);
    d0 = n_disp;
    wr(48'h7777_0000_0007, 1'b1);
    drain(50);
    chk("t6_post_reset_dispatch", 64'(n_disp), 64'(d0 + 1));
    chk("t6_post_reset_cmd", 64'(out_command), 48'h7777_0000_0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
